// File: rtl/seg_scan_pkg.sv
// Shared types, default parameters and helpers for the 7-segment scan driver.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS_DEF   = 4;
    localparam int unsigned PRESCALE_DEF     = 50000;
    localparam int unsigned BLANK_CYCLES_DEF = 2;
    localparam int unsigned MAX_DIGITS       = 8;
    localparam int unsigned BUS_W            = 4 * MAX_DIGITS;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_e;

    // Pick hex digit idx out of a value bus zero-extended to MAX_DIGITS nibbles.
    function automatic logic [3:0] nibble_sel(input logic [BUS_W-1:0] bus, input logic [2:0] idx);
        return bus[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Host-side bus of the scan driver: value load/config in, decoder nibble and anode enables out.
interface seg_scan_if import seg_scan_pkg::*; #(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_mask;
    logic                    lz_suppress;
    logic [3:0]              nibble_out;
    logic [NUM_DIGITS-1:0]   digit_en_n;
    logic                    frame_start;

    modport master (
        output load, value, digit_mask, lz_suppress,
        input  nibble_out, digit_en_n, frame_start
    );

    modport slave (
        input  load, value, digit_mask, lz_suppress,
        output nibble_out, digit_en_n, frame_start
    );
endinterface

// File: rtl/seg_scan_tick.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 while enabled and flags the last cycle of a slot.
module seg_scan_tick import seg_scan_pkg::*; #(
    parameter int unsigned PRESCALE = PRESCALE_DEF,
    localparam int unsigned CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             slot_wrap_c_o
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d         = cnt_q;
        slot_wrap_c_o = en_i && (cnt_q == LAST_CNT);
        if (slot_wrap_c_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver feeding a registered hex decoder,
// with blanking dead time, leading-zero suppression and a frame-synchronous value buffer.
module seg_scan_driver import seg_scan_pkg::*; #(
    parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int unsigned PRESCALE     = PRESCALE_DEF,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e           state_q, state_d;
    logic                  run_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      active_q, active_d;
    logic [VAL_W-1:0]      pending_q, pending_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
    logic                  frame_q, frame_d;

    logic [CNT_W-1:0]      cnt;
    logic                  slot_wrap_c;
    logic                  swap_c;
    logic                  zero_run_c;
    logic [NUM_DIGITS-1:0] tail_zero_c;
    logic                  lit_c;

    // run_q holds the counter for one cycle after reset so the first released cycle is slot 0, cnt 0.
    seg_scan_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk           (clk),
        .rst           (rst),
        .en_i          (run_q),
        .cnt_o         (cnt),
        .slot_wrap_c_o (slot_wrap_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_vld_d  = pend_vld_q;
        swap_c      = slot_wrap_c && (idx_q == LAST_IDX);
        zero_run_c  = 1'b1;
        tail_zero_c = '0;

        case (state_q)
            ST_BLANK: if (run_q && (cnt == BLANK_LAST)) state_d = ST_SHOW;
            ST_SHOW:  if (slot_wrap_c) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        if (slot_wrap_c) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        // Frame-boundary swap; a load on that same edge goes straight to active.
        if (swap_c) begin
            if (bus.load) begin
                active_d = bus.value;
            end else if (pend_vld_q) begin
                active_d = pending_q;
            end
            pend_vld_d = 1'b0;
        end else if (bus.load) begin
            pending_d  = bus.value;
            pend_vld_d = 1'b1;
        end

        // tail_zero_c[k]: every nibble from k up to the top digit is zero.
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run_c     = zero_run_c && (nibble_sel(BUS_W'(active_d), 3'(k)) == 4'h0);
            tail_zero_c[k] = zero_run_c;
        end

        lit_c    = bus.digit_mask[idx_d]
                   && !(bus.lz_suppress && (idx_d != '0) && tail_zero_c[idx_d]);
        nibble_d = nibble_sel(BUS_W'(active_d), 3'(idx_d));
        en_n_d   = '1;
        if ((state_d == ST_SHOW) && lit_c) begin
            en_n_d[idx_d] = 1'b0;
        end
        frame_d = !run_q || swap_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_BLANK;
            run_q      <= 1'b0;
            idx_q      <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            nibble_q   <= '0;
            en_n_q     <= '1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            nibble_q   <= nibble_d;
            en_n_q     <= en_n_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.nibble_out  = nibble_q;
    assign bus.digit_en_n  = en_n_q;
    assign bus.frame_start = frame_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
- Sits directly upstream of the registered hex-to-7-segment decoder. It feeds the decoder one 4-bit nibble at a time and drives the active-low digit enables.
- Enable timing absorbs the decoder's 1-cycle latency and adds dead time between digits so segments never ghost.
- Displayed value is double-buffered and swaps only at frame boundaries, so no tearing.

Parameters:
- NUM_DIGITS, 4, number of display digits; legal 1..8.
- PRESCALE, 50000, clk cycles per digit slot; must be > BLANK_CYCLES+1.
- BLANK_CYCLES, 2, dead cycles at the start of each slot with all enables off; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- load  in  1  single-cycle strobe; captures value into pending buffer.
- value  in  4*NUM_DIGITS  hex digits; digit 0 = bits [3:0].
- digit_mask  in  NUM_DIGITS  1 = digit may light, 0 = digit forced dark.
- lz_suppress  in  1  1 = blank leading zeros.
- nibble_out  out  4  nibble to decoder dataIn.
- digit_en_n  out  NUM_DIGITS  active-low digit enables (anodes).
- frame_start  out  1  1-cycle pulse at the start of the digit-0 slot.

Behaviour:
- Reset (rst=0 at clk edge, takes effect on that edge, also mid-scan):
  - cnt=0, idx=0, active=0, pending=0, pending_valid=0.
  - nibble_out=0, digit_en_n=all ones, frame_start=0.
  - The first cycle after release is cnt=0 of digit 0.
- Slot counter cnt runs 0..PRESCALE-1. At cnt=PRESCALE-1 it wraps to 0 and idx advances (NUM_DIGITS-1 wraps to 0).
- nibble_out:
  - Registered; equals active[idx] throughout the slot.
  - Changes in the cnt=0 cycle.
  - The decoder output is valid from cnt=1.
- Two-state FSM per slot:
  - BLANK: cnt < BLANK_CYCLES; digit_en_n all ones.
  - SHOW: cnt >= BLANK_CYCLES; digit_en_n[idx]=0 if the digit is lit, all other bits 1.
  - BLANK -> SHOW at cnt=BLANK_CYCLES.
  - SHOW -> BLANK at slot wrap.
- Digit lit condition: digit_mask[idx]=1 AND NOT suppressed.
- Leading-zero suppression, when lz_suppress=1:
  - Digit k is suppressed if all nibbles k..NUM_DIGITS-1 of active are 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Computed from active; lz_suppress is sampled per cycle.
- Buffering:
  - load=1 writes value to pending and sets pending_valid.
  - A later load before the swap overwrites pending; last load wins.
  - Swap happens on the edge where cnt=PRESCALE-1 and idx=NUM_DIGITS-1: if pending_valid, active<=pending and pending_valid<=0.
  - The new active value is used by nibble_out from the cnt=0 cycle of digit 0.
  - If load=1 on the swap edge, value bypasses straight into active and pending_valid is cleared.
- frame_start=1 exactly in cycles with idx=0 and cnt=0, including the first cycle after reset.
- Inputs are assumed synchronous to clk; there is no handshake back-pressure, and load is always accepted.

Decomposition:
- Package seg_scan_pkg holds:
  - scan state enum {ST_BLANK, ST_SHOW}.
  - Defaults for NUM_DIGITS, PRESCALE, BLANK_CYCLES.
  - Function nibble_sel(bus, idx).
- Sub-module seg_scan_tick: prescaler producing cnt and a slot_wrap pulse. Parameterised by PRESCALE.

Test Plan:
Bench uses NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, digit_mask=4'b1111, lz_suppress=0 unless stated.
1. Hold rst=0 for 5 cycles mid-run -> next edge digit_en_n=4'b1111, nibble_out=0, frame_start=0. After release, frame_start=1 in the first cycle.
2. load 16'h1A3F in frame 0 -> from frame 1:
   - nibble_out = F,3,A,1 for 8 cycles each.
   - digit_en_n=4'b1110 only at cnt 2..7 of slot 0, 4'b1101 at cnt 2..7 of slot 1, and so on.
   - All ones at cnt 0..1 of every slot.
3. lz_suppress=1:
   - 16'h0042 -> digits 2,3 never enabled; digits 0,1 enabled.
   - 16'h0000 -> only digit 0 enabled, nibble 0.
   - 16'h0100 -> digits 0..2 enabled.
4. Tearing and bypass:
   - load 16'h1111 at idx=1, then 16'h2222 at idx=2 of the same frame -> 1111 never appears on nibble_out; next frame shows 2.
   - load 16'h3333 on the swap edge -> 3 appears in the very next slot.
5. digit_mask=4'b0101 with value 16'h8888 -> digit_en_n bits 1 and 3 stay 1 for 3 full frames; bits 0 and 2 pulse as in scenario 2.
6. Assert rst for one cycle at idx=2, cnt=5 -> reset values on the next edge. Scanning restarts at digit 0, active=0, and the previously loaded pending value is discarded.
